ram_arbiter: RTL and testbench

Two-port request arbiter and sequencer for the single-port synchronous `ram` block. It shares the `ram` between two requesters: port A (instruction fetch) and port B (data load/store). Requests are granted round-robin. Each granted request is sequenced through the RAM's one-cycle registered read path. Completion is returned as a one-cycle acknowledge pulse with registered read data.

---
 rtl/ram_arbiter.sv | 97 +++++++++
 tb/tb_ram_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
// Round-robin arbiter that shares one single-port synchronous RAM between an
// instruction-fetch port (A) and a data port (B), one access every four cycles.
module ram_arbiter #(
  parameter int BITS    = 32,
  parameter int RAMSIZE = 512,
  parameter int ADDR    = $clog2(RAMSIZE)
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            a_req,
  input  logic            a_we,
  input  logic [ADDR-1:0] a_addr,
  input  logic [BITS-1:0] a_wdata,
  output logic            a_ack,
  output logic [BITS-1:0] a_rdata,
  input  logic            b_req,
  input  logic            b_we,
  input  logic [ADDR-1:0] b_addr,
  input  logic [BITS-1:0] b_wdata,
  output logic            b_ack,
  output logic [BITS-1:0] b_rdata,
  output logic            busy,
  output logic            ram_read,
  output logic            ram_write,
  output logic [ADDR-1:0] ram_addr,
  output logic [BITS-1:0] ram_din,
  input  logic [BITS-1:0] ram_dout
);

  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, DONE} state_t;

  state_t state;
  logic   gnt;
  logic   last;
  logic   op_we;
  logic   pick_b;

  // B wins when it requests alone, or on a tie when A held the previous grant.
  always_comb pick_b = b_req & (~a_req | ~last);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      gnt       <= 1'b0;
      last      <= 1'b1;
      op_we     <= 1'b0;
      busy      <= 1'b0;
      ram_read  <= 1'b0;
      ram_write <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      a_ack     <= 1'b0;
      b_ack     <= 1'b0;
      a_rdata   <= '0;
      b_rdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (a_req || b_req) begin
            gnt       <= pick_b;
            last      <= pick_b;
            op_we     <= pick_b ? b_we : a_we;
            ram_addr  <= pick_b ? b_addr : a_addr;
            ram_din   <= pick_b ? b_wdata : a_wdata;
            ram_write <= pick_b ? b_we : a_we;
            ram_read  <= pick_b ? ~b_we : ~a_we;
            busy      <= 1'b1;
            state     <= ACCESS;
          end
        end
        ACCESS: begin
          ram_read  <= 1'b0;
          ram_write <= 1'b0;
          state     <= WAIT;
        end
        WAIT: begin
          // ram_dout now holds the word addressed during ACCESS.
          if (!op_we) begin
            if (gnt) b_rdata <= ram_dout;
            else     a_rdata <= ram_dout;
          end
          a_ack <= ~gnt;
          b_ack <= gnt;
          state <= DONE;
        end
        DONE: begin
          a_ack <= 1'b0;
          b_ack <= 1'b0;
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ram_arbiter.sv
// Self-checking bench for ram_arbiter: directed scenarios followed by random
// traffic, checked against a memory-level reference model and a latency window.
module tb_ram_arbiter;

  localparam int BITS    = 32;
  localparam int RAMSIZE = 512;
  localparam int ADDR    = 9;

  logic            clk = 1'b0;
  logic            rst_n;
  logic            a_req, a_we, b_req, b_we;
  logic [ADDR-1:0] a_addr, b_addr;
  logic [BITS-1:0] a_wdata, b_wdata;
  logic            a_ack, b_ack, busy, ram_read, ram_write;
  logic [BITS-1:0] a_rdata, b_rdata, ram_din;
  logic [ADDR-1:0] ram_addr;
  bit   [BITS-1:0] ram_dout;
  bit   [BITS-1:0] mem [RAMSIZE];

  always #5 clk = ~clk;

  ram_arbiter #(.BITS(BITS), .RAMSIZE(RAMSIZE), .ADDR(ADDR)) dut (
    .clk(clk), .rst_n(rst_n),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
    .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
    .b_ack(b_ack), .b_rdata(b_rdata),
    .busy(busy), .ram_read(ram_read), .ram_write(ram_write),
    .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
  );

  // Behavioural single-port RAM with a one-cycle registered read.
  always @(posedge clk) begin
    if (ram_write) mem[ram_addr] <= ram_din;
    if (ram_read)  ram_dout <= mem[ram_addr];
  end

  int checks = 0;
  int errors = 0;

  bit              pend [2];
  bit              low_seen [2];
  int              age [2];
  int              last_lat [2];
  int              acks [2];
  bit              op_we [2];
  logic [ADDR-1:0] op_addr [2];
  logic [BITS-1:0] op_wdata [2];
  logic [BITS-1:0] ref_rdata [2];
  bit   [BITS-1:0] ref_mem [RAMSIZE];
  bit   [1:0]      strobe_mask;
  int              strobes = 0;
  int              busy_low = 0;
  int              ack_log [$];

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic drive_port(input int p);
    if (p == 0) begin
      a_req = pend[0]; a_we = op_we[0]; a_addr = op_addr[0]; a_wdata = op_wdata[0];
    end else begin
      b_req = pend[1]; b_we = op_we[1]; b_addr = op_addr[1]; b_wdata = op_wdata[1];
    end
  endtask

  task automatic apply_stimulus(input int p, input bit we, input logic [ADDR-1:0] addr,
                                input logic [BITS-1:0] wdata);
    op_we[p] = we; op_addr[p] = addr; op_wdata[p] = wdata;
    pend[p] = 1'b1; age[p] = 0; low_seen[p] = 1'b0;
    drive_port(p);
  endtask

  task automatic apply_random(input int p);
    apply_stimulus(p, bit'($urandom % 2), ADDR'($urandom % 16), $urandom);
  endtask

  // Advance to the next falling edge and score strobes and acks against the model.
  task automatic clock_cycle();
    int p;
    bit [1:0] mask;
    @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      if (pend[i]) age[i]++;
      else low_seen[i] = 1'b1;
    end
    if (!busy) busy_low++;
    if (ram_read || ram_write) begin
      strobes++;
      check_output("strobe_excl", 32'(ram_read & ram_write), 32'd0);
      check_output("strobe_outstanding", 32'(strobe_mask), 32'd0);
      mask = 2'b00;
      for (int i = 0; i < 2; i++)
        if (pend[i] && op_we[i] == ram_write && op_addr[i] == ram_addr &&
            (!ram_write || op_wdata[i] == ram_din))
          mask[i] = 1'b1;
      check_output("strobe_match", 32'(mask != 2'b00), 32'd1);
      strobe_mask = mask;
    end
    if (a_ack || b_ack) begin
      check_output("ack_excl", 32'(a_ack & b_ack), 32'd0);
      p = b_ack ? 1 : 0;
      check_output("ack_pending", 32'(pend[p]), 32'd1);
      check_output("ack_source", 32'(strobe_mask[p]), 32'd1);
      check_output("ack_latency", 32'(age[p] >= 3 && age[p] <= 7), 32'd1);
      if (pend[p]) begin
        if (op_we[p]) ref_mem[op_addr[p]] = op_wdata[p];
        else ref_rdata[p] = ref_mem[op_addr[p]];
      end
      check_output("a_rdata", a_rdata, ref_rdata[0]);
      check_output("b_rdata", b_rdata, ref_rdata[1]);
      last_lat[p] = age[p];
      acks[p]++;
      ack_log.push_back(p);
      pend[p] = 1'b0;
      strobe_mask = 2'b00;
      drive_port(p);
    end
  endtask

  task automatic wait_done(input int bound);
    int n = 0;
    while ((pend[0] || pend[1]) && n < bound) begin
      clock_cycle();
      n++;
    end
    check_output("drain", 32'({pend[0], pend[1]}), 32'd0);
    clock_cycle();
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog expired observed=running expected=finished");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    int s0, a0, b0, bl0, lg0, first;
    rst_n = 1'b0;
    a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
    b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
    ref_rdata[0] = '0; ref_rdata[1] = '0;
    strobe_mask = 2'b00;
    repeat (3) @(negedge clk);

    check_output("rst_busy", 32'(busy), 32'd0);
    check_output("rst_ram_read", 32'(ram_read), 32'd0);
    check_output("rst_ram_write", 32'(ram_write), 32'd0);
    check_output("rst_a_ack", 32'(a_ack), 32'd0);
    check_output("rst_b_ack", 32'(b_ack), 32'd0);
    check_output("rst_ram_addr", 32'(ram_addr), 32'd0);
    check_output("rst_ram_din", ram_din, 32'd0);
    check_output("rst_a_rdata", a_rdata, 32'd0);
    check_output("rst_b_rdata", b_rdata, 32'd0);
    rst_n = 1'b1;
    clock_cycle();

    s0 = strobes;
    apply_stimulus(0, 1'b1, 9'h004, 32'h00800055);
    wait_done(20);
    check_output("a_wr_strobes", 32'(strobes - s0), 32'd1);
    check_output("a_wr_latency", 32'(last_lat[0]), 32'd3);
    check_output("a_wr_rdata_kept", a_rdata, 32'd0);

    s0 = strobes;
    apply_stimulus(0, 1'b0, 9'h004, 32'h0);
    wait_done(20);
    check_output("a_rd_strobes", 32'(strobes - s0), 32'd1);
    check_output("a_rd_latency", 32'(last_lat[0]), 32'd3);
    check_output("a_rd_data", a_rdata, 32'h00800055);

    apply_stimulus(1, 1'b1, 9'h055, 32'h0000F7F7);
    wait_done(20);
    check_output("b_wr_latency", 32'(last_lat[1]), 32'd3);

    // Simultaneous reads: A wins the first tie since B held the last grant.
    apply_stimulus(0, 1'b0, 9'h004, 32'h0);
    apply_stimulus(1, 1'b0, 9'h055, 32'h0);
    wait_done(30);
    check_output("tie_a_latency", 32'(last_lat[0]), 32'd3);
    check_output("tie_b_latency", 32'(last_lat[1]), 32'd7);
    check_output("tie_a_data", a_rdata, 32'h00800055);
    check_output("tie_b_data", b_rdata, 32'h0000F7F7);
    check_output("tie_order", 32'(ack_log[$]), 32'd1);

    first = 1 - ack_log[$];
    a0 = acks[0]; b0 = acks[1]; bl0 = busy_low; lg0 = ack_log.size();
    apply_random(0);
    apply_random(1);
    for (int c = 0; c < 32; c++) begin
      clock_cycle();
      for (int p = 0; p < 2; p++)
        if (!pend[p] && low_seen[p]) apply_random(p);
    end
    check_output("cont_a_acks", 32'(acks[0] - a0), 32'd4);
    check_output("cont_b_acks", 32'(acks[1] - b0), 32'd4);
    check_output("cont_busy_low", 32'(busy_low - bl0), 32'd8);
    if (ack_log.size() > lg0) check_output("cont_first", 32'(ack_log[lg0]), 32'(first));
    for (int i = lg0 + 1; i < ack_log.size(); i++)
      check_output("cont_alternate", 32'(ack_log[i] != ack_log[i-1]), 32'd1);
    wait_done(30);

    for (int i = 0; i < 4; i++) begin
      apply_stimulus(1, 1'b1, ADDR'(9'h100 + i), 32'(9'h100 + i));
      wait_done(20);
      check_output("b_alone_latency", 32'(last_lat[1]), 32'd3);
    end
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(0, 1'b0, ADDR'(9'h100 + i), 32'h0);
      wait_done(20);
      check_output("readback", a_rdata, 32'(9'h100 + i));
    end

    // Abort a write while its strobe is on the bus.
    apply_stimulus(0, 1'b1, 9'h1FF, 32'hDEADBEEF);
    clock_cycle();
    check_output("abort_strobe_seen", 32'(ram_write), 32'd1);
    rst_n = 1'b0;
    #1;
    check_output("abort_ram_write", 32'(ram_write), 32'd0);
    check_output("abort_ram_read", 32'(ram_read), 32'd0);
    check_output("abort_busy", 32'(busy), 32'd0);
    check_output("abort_ram_addr", 32'(ram_addr), 32'd0);
    pend[0] = 1'b0;
    drive_port(0);
    strobe_mask = 2'b00;
    ref_rdata[0] = '0; ref_rdata[1] = '0;
    a0 = acks[0];
    clock_cycle();
    rst_n = 1'b1;
    repeat (6) clock_cycle();
    check_output("abort_no_ack", 32'(acks[0] - a0), 32'd0);
    check_output("abort_a_rdata", a_rdata, 32'd0);

    for (int c = 0; c < 400; c++) begin
      clock_cycle();
      for (int p = 0; p < 2; p++)
        if (!pend[p] && low_seen[p] && ($urandom % 3 == 0)) apply_random(p);
    end
    wait_done(40);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
